video_rx_meter: RTL
===================

# video_rx_meter

Synthesizable receiver/checker for the internal pixel-stream protocol (di/de/hs/vs) used by the scaler chain. It sits at the sink end of any video stage, such as after scaler_v, and measures each frame: active width, active height and pixel checksum. It also flags protocol and geometry violations in sticky error bits. It is the hardware counterpart of the stream source: it reports what a stage actually emitted.

## Interface
- DATA_WIDTH, 8, pixel width of di_i
- CNT_WIDTH, 16, width of pixel/line counters (saturating)
- SUM_WIDTH, 32, width of per-frame pixel checksum (wraps modulo 2^SUM_WIDTH)

- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset; synchronous, active-high
- di_i  in  DATA_WIDTH  pixel data, valid when de_i=1
- de_i  in  1  pixel valid
- hs_i  in  1  line blanking, high between lines
- vs_i  in  1  frame blanking, high between frames
- err_clr_i  in  1  clears err_o
- width_o  out  CNT_WIDTH  pixels in first counted line of last completed frame
- height_o  out  CNT_WIDTH  counted lines (lines with ≥1 pixel) of last completed frame
- sum_o  out  SUM_WIDTH  sum of all counted di_i in last completed frame
- frame_cnt_o  out  16  completed frames since reset, wraps
- frame_done_o  out  1  one-cycle pulse when width/height/sum update
- err_o  out  3  sticky: [0] line length ≠ width of first line; [1] de_i=1 while hs_i=1 or vs_i=1; [2] counter saturated

## Operation
- A pixel counts only when de_i=1, hs_i=0 and vs_i=0. On a counted pixel, the pixel counter increments and the running sum adds di_i, zero-extended.
- States:
  - SYNC: entered at reset. Moves to VBLANK when vs_i=1. Measurement never starts mid-frame.
  - VBLANK: moves to HBLANK when vs_i=0. Clears the line counter, running sum and first-line flag.
  - HBLANK: moves to LINE when hs_i=0 and vs_i=0. Clears the pixel counter. Goes back to VBLANK if vs_i=1.
  - LINE: counts pixels. Exits when hs_i=1 or vs_i=1.
- Line close, on exit from LINE:
  - A line with pixel count 0 is ignored.
  - Otherwise the line counter increments.
  - For the first counted line, the first-line width is latched.
  - For later lines, a count different from the first-line width sets err_o[0].
- Frame close: vs_i sampled 0→1 from HBLANK or LINE.
  - Any open line is closed first, in the same cycle.
  - Then width_o, height_o and sum_o are loaded, frame_cnt_o increments and frame_done_o pulses. The next state is VBLANK.
  - A frame with zero counted lines still closes, with width_o=0, height_o=0, sum_o=0.
- Saturation: the pixel and line counters stop at 2^CNT_WIDTH−1 and set err_o[2]. Further pixels are still summed.
- de_i=1 with hs_i=1 or vs_i=1 sets err_o[1] in every state except SYNC. That pixel is not counted or summed.
- err_o bits are cleared only by rst or err_clr_i. If err_clr_i and a new error occur in the same cycle, the error bit ends set.

## Timing
- Reset values (cycle after rst sampled high): all outputs 0, state SYNC, internal counters 0.
- Outputs are registered. For a vs_i rise sampled at edge N:
  - frame_done_o=1 during cycle N+1.
  - width_o, height_o, sum_o and frame_cnt_o show new values from N+1 and hold until the next frame close.
- err_o bit sets are visible one cycle after the offending sample.
- Fully streaming: accepts de_i every cycle, with no backpressure.
- Minimum blanking: one cycle of hs_i=1 separates lines; one cycle of vs_i=1 separates frames.
- hs_i and vs_i rising in the same cycle: the line is closed and counted in height_o; this is the normal end of frame.
- rst mid-frame: returns to SYNC and produces no frame_done_o for the interrupted frame.

## Test plan
- Case 1, nominal frame:
  - Stimulus: rst pulse, then an 8x8 frame with all pixels 3, de_i every 4th cycle, 44-cycle hs_i gaps, vs_i high before and after.
  - Response: exactly one frame_done_o pulse; width_o=8, height_o=8, sum_o=192, frame_cnt_o=1, err_o=0.
- Case 2, release into an active frame:
  - Stimulus: release rst while vs_i=0 mid-frame.
  - Response: no frame_done_o for the partial frame; the next full 8x8 frame gives height_o=8 and frame_cnt_o=1.
- Case 3, short line:
  - Stimulus: 8x8 frame where line 4 has 7 pixels.
  - Response: err_o[0]=1, width_o=8, height_o=8, sum_o reduced by one pixel.
- Case 4, de during blanking and error clear:
  - Stimulus: de_i=1 with di_i=200 while hs_i=1, then err_clr_i pulse.
  - Response: err_o[1]=1 one cycle later; sum_o excludes 200; err_o=0 one cycle after err_clr_i.
- Case 5, back-to-back frames with varying data:
  - Stimulus: two frames, with di_i equal to the pixel x index (0..7) in an 8x8 frame.
  - Response: sum_o=224 both times; frame_cnt_o goes 1 then 2; frame_done_o pulses exactly once per frame.
- Case 6, saturation:
  - Stimulus: CNT_WIDTH=4 with 20-pixel lines.
  - Response: width_o=15, err_o[2]=1.

Source files
------------

// File: rtl/video_rx_meter.sv
// Pixel-stream sink meter: measures active width, height and pixel checksum of
// each di/de/hs/vs frame, and keeps sticky protocol/geometry error flags.
module video_rx_meter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned SUM_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] di_i,
  input  logic                  de_i,
  input  logic                  hs_i,
  input  logic                  vs_i,
  input  logic                  err_clr_i,
  output logic [CNT_WIDTH-1:0]  width_o,
  output logic [CNT_WIDTH-1:0]  height_o,
  output logic [SUM_WIDTH-1:0]  sum_o,
  output logic [15:0]           frame_cnt_o,
  output logic                  frame_done_o,
  output logic [2:0]            err_o
);

  typedef enum logic [1:0] {SYNC, VBLANK, HBLANK, LINE} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                state;
  logic [CNT_WIDTH-1:0]  pix_cnt;
  logic [CNT_WIDTH-1:0]  line_cnt;
  logic [CNT_WIDTH-1:0]  first_w;
  logic                  first_done;
  logic [SUM_WIDTH-1:0]  sum;

  logic                  pix;
  logic [SUM_WIDTH-1:0]  pix_val;
  logic                  line_close;
  logic                  frame_close;
  logic [CNT_WIDTH-1:0]  line_cnt_c;
  logic [CNT_WIDTH-1:0]  first_w_c;
  logic                  first_done_c;
  logic                  len_err;
  logic                  line_sat;
  logic                  pix_sat;
  logic                  blank_de;
  logic [2:0]            err_set;

  assign pix     = de_i & ~hs_i & ~vs_i;
  assign pix_val = SUM_WIDTH'(di_i);

  // Line-close bookkeeping is computed here so a frame close in the same
  // cycle can load outputs that already include the final line.
  always_comb begin
    line_close   = (state == LINE) && (hs_i || vs_i) && (pix_cnt != '0);
    frame_close  = ((state == HBLANK) || (state == LINE)) && vs_i;
    line_cnt_c   = line_cnt;
    first_w_c    = first_w;
    first_done_c = first_done;
    len_err      = 1'b0;
    line_sat     = 1'b0;
    if (line_close) begin
      if (line_cnt == CNT_MAX) line_sat = 1'b1;
      else                     line_cnt_c = line_cnt + CNT_ONE;
      if (!first_done) begin
        first_w_c    = pix_cnt;
        first_done_c = 1'b1;
      end else if (pix_cnt != first_w) begin
        len_err = 1'b1;
      end
    end
    pix_sat  = ((state == LINE) && pix && (pix_cnt == CNT_MAX));
    blank_de = de_i && (hs_i || vs_i) && (state != SYNC);
    err_set  = {line_sat | pix_sat, blank_de, len_err};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SYNC;
      pix_cnt      <= '0;
      line_cnt     <= '0;
      first_w      <= '0;
      first_done   <= 1'b0;
      sum          <= '0;
      width_o      <= '0;
      height_o     <= '0;
      sum_o        <= '0;
      frame_cnt_o  <= '0;
      frame_done_o <= 1'b0;
      err_o        <= '0;
    end else begin
      frame_done_o <= 1'b0;
      err_o        <= (err_clr_i ? 3'b000 : err_o) | err_set;

      case (state)
        SYNC: begin
          if (vs_i) state <= VBLANK;
        end

        // A line may start in the very cycle vs falls; its first pixel is kept.
        VBLANK: begin
          line_cnt   <= '0;
          first_w    <= '0;
          first_done <= 1'b0;
          sum        <= '0;
          pix_cnt    <= '0;
          if (!vs_i) begin
            if (hs_i) begin
              state <= HBLANK;
            end else begin
              state <= LINE;
              if (pix) begin
                pix_cnt <= CNT_ONE;
                sum     <= pix_val;
              end
            end
          end
        end

        HBLANK: begin
          pix_cnt <= '0;
          if (vs_i) begin
            state <= VBLANK;
          end else if (!hs_i) begin
            state <= LINE;
            if (pix) begin
              pix_cnt <= CNT_ONE;
              sum     <= sum + pix_val;
            end
          end
        end

        LINE: begin
          if (pix) begin
            sum <= sum + pix_val;
            if (pix_cnt != CNT_MAX) pix_cnt <= pix_cnt + CNT_ONE;
          end
          if (hs_i || vs_i) begin
            line_cnt   <= line_cnt_c;
            first_w    <= first_w_c;
            first_done <= first_done_c;
            pix_cnt    <= '0;
            state      <= vs_i ? VBLANK : HBLANK;
          end
        end

        default: state <= SYNC;
      endcase

      if (frame_close) begin
        width_o      <= first_w_c;
        height_o     <= line_cnt_c;
        sum_o        <= sum;
        frame_cnt_o  <= frame_cnt_o + 16'd1;
        frame_done_o <= 1'b1;
      end
    end
  end

endmodule
